// File: rtl/pwm_pkg.sv
// Shared types and saturating step helpers for the PWM ramp sequencer and
// related PWM channel logic.
package pwm_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD,
    SHUTDOWN
  } ramp_state_t;

  // Step toward tgt from below; the one-bit-wider sum cannot wrap.
  function automatic logic [31:0] sat_up(input logic [31:0] cur,
                                         input logic [31:0] step,
                                         input logic [31:0] tgt);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    return (sum > {1'b0, tgt}) ? tgt : sum[31:0];
  endfunction

  // Step toward tgt from above; the comparison is done before subtracting.
  function automatic logic [31:0] sat_dn(input logic [31:0] cur,
                                         input logic [31:0] step,
                                         input logic [31:0] tgt);
    logic [32:0] floor_sum;
    floor_sum = {1'b0, tgt} + {1'b0, step};
    return ({1'b0, cur} < floor_sum) ? tgt : (cur - step);
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running W-bit period counter; period_tick marks the last clock of each
// 2^W-clock PWM period.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  logic [W-1:0] pcnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else     pcnt <= pcnt + W'(1);
  end

  assign period_tick = (pcnt == '1);

endmodule

// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop sequencer: accepts a target duty and ramps the PWM
// duty toward it in fixed steps on period boundaries; kill forces duty to 0.
module pwm_ramp_controller
  import pwm_pkg::*;
#(
  parameter int W                = PWM_W,
  parameter int STEP             = 4,
  parameter int PERIODS_PER_STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kill,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_duty,
  output logic         tgt_ready,
  output logic [W-1:0] duty_cycle,
  output logic         busy,
  output logic         at_target
);

  localparam int DIV_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIODS_PER_STEP - 1);

  ramp_state_t      state, state_n;
  logic [W-1:0]     tgt, tgt_n;
  logic [W-1:0]     duty_n, stepped;
  logic [DIV_W-1:0] divcnt, div_n;
  logic             period_tick;
  logic             accept;

  pwm_period_timer #(.W(W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick)
  );

  assign tgt_ready = (state != SHUTDOWN) && !kill;
  assign accept    = tgt_valid && tgt_ready;
  assign busy      = (state == RAMP);
  assign at_target = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= '0;
      divcnt     <= '0;
      duty_cycle <= '0;
    end else begin
      state      <= state_n;
      tgt        <= tgt_n;
      divcnt     <= div_n;
      duty_cycle <= duty_n;
    end
  end

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    div_n   = divcnt;
    duty_n  = duty_cycle;
    stepped = (tgt > duty_cycle)
            ? W'(sat_up(32'(duty_cycle), 32'(STEP), 32'(tgt)))
            : W'(sat_dn(32'(duty_cycle), 32'(STEP), 32'(tgt)));

    if (kill) begin
      state_n = SHUTDOWN;
      tgt_n   = '0;
      div_n   = '0;
      duty_n  = '0;
    end else if (state == SHUTDOWN) begin
      state_n = IDLE;
    end else if (accept) begin
      // A period tick coinciding with an accept is deliberately not counted.
      tgt_n   = tgt_duty;
      div_n   = '0;
      state_n = (tgt_duty == duty_cycle) ? HOLD : RAMP;
    end else if ((state == RAMP) && period_tick) begin
      if (divcnt == DIV_LAST) begin
        div_n  = '0;
        duty_n = stepped;
        if (stepped == tgt) state_n = HOLD;
      end else begin
        div_n = divcnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: directed stimulus on a default instance and a
// STEP=100/PERIODS_PER_STEP=1 instance, checked every cycle against a model.
module tb_pwm_ramp_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kill, tgt_valid, tgt_ready, busy, at_target;
  logic [7:0] tgt_duty, duty_cycle;
  logic       f_kill, f_valid, f_ready, f_busy, f_at_target;
  logic [7:0] f_duty, f_duty_cycle;

  always #5 clk = ~clk;

  pwm_ramp_controller dut (
    .clk(clk), .rst(rst), .kill(kill), .tgt_valid(tgt_valid),
    .tgt_duty(tgt_duty), .tgt_ready(tgt_ready), .duty_cycle(duty_cycle),
    .busy(busy), .at_target(at_target)
  );

  pwm_ramp_controller #(.W(8), .STEP(100), .PERIODS_PER_STEP(1)) dut_fast (
    .clk(clk), .rst(rst), .kill(f_kill), .tgt_valid(f_valid),
    .tgt_duty(f_duty), .tgt_ready(f_ready), .duty_cycle(f_duty_cycle),
    .busy(f_busy), .at_target(f_at_target)
  );

  // mode: 0 idle, 1 ramping, 2 holding, 3 shut down
  typedef struct {
    int duty;
    int tgt;
    int mode;
    int ticks;
    int cyc;
  } mdl_t;

  mdl_t m0, m1;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.duty = 0; m.tgt = 0; m.mode = 0; m.ticks = 0; m.cyc = 0;
    return m;
  endfunction

  // One clock of the model: period ticks are every 256th clock since reset,
  // and steps land on every pps-th tick counted from the last acceptance.
  function automatic mdl_t adv(mdl_t m, bit k, bit v, int req, int step, int pps);
    bit tick;
    tick  = (m.cyc % 256) == 255;
    m.cyc = m.cyc + 1;
    if (k) begin
      m.mode = 3; m.duty = 0; m.tgt = 0; m.ticks = 0;
    end else if (m.mode == 3) begin
      m.mode = 0;
    end else if (v) begin
      m.tgt   = req;
      m.ticks = 0;
      m.mode  = (req == m.duty) ? 2 : 1;
    end else if (m.mode == 1 && tick) begin
      m.ticks = m.ticks + 1;
      if (m.ticks % pps == 0) begin
        if (m.tgt > m.duty) m.duty = (m.duty + step > m.tgt) ? m.tgt : m.duty + step;
        else                m.duty = (m.duty - step < m.tgt) ? m.tgt : m.duty - step;
        if (m.duty == m.tgt) m.mode = 2;
      end
    end
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
  endtask

  task automatic goto(input int c);
    while (edge_cnt < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = mdl_reset();
      m1 = mdl_reset();
      edge_cnt = 0;
    end else begin
      m0 = adv(m0, kill, tgt_valid, int'(tgt_duty), 4, 2);
      m1 = adv(m1, f_kill, f_valid, int'(f_duty), 100, 1);
      edge_cnt = m0.cyc;
    end
  end

  always @(negedge clk) begin
    check("duty",        int'(duty_cycle),   m0.duty);
    check("ready",       int'(tgt_ready),    int'(m0.mode != 3 && !kill));
    check("busy",        int'(busy),         int'(m0.mode == 1));
    check("at_target",   int'(at_target),    int'(m0.mode == 2));
    check("f_duty",      int'(f_duty_cycle), m1.duty);
    check("f_ready",     int'(f_ready),      int'(m1.mode != 3 && !f_kill));
    check("f_busy",      int'(f_busy),       int'(m1.mode == 1));
    check("f_at_target", int'(f_at_target),  int'(m1.mode == 2));
  end

  // Fast instance: 0 -> 255 in steps of 100 on consecutive ticks, no wrap.
  initial begin
    f_kill = 1'b0; f_valid = 1'b0; f_duty = '0;
    goto(19);  f_valid = 1'b1; f_duty = 8'd255;
    goto(20);  f_valid = 1'b0;
    goto(255); check("lit_f_pre", int'(f_duty_cycle), 0);
               check("lit_f_busy", int'(f_busy), 1);
    goto(256); check("lit_f_100", int'(f_duty_cycle), 100);
    goto(511); check("lit_f_hold100", int'(f_duty_cycle), 100);
    goto(512); check("lit_f_200", int'(f_duty_cycle), 200);
    goto(768); check("lit_f_255", int'(f_duty_cycle), 255);
               check("lit_f_at", int'(f_at_target), 1);
               check("lit_f_busy_end", int'(f_busy), 0);
  end

  initial begin
    kill = 1'b0; tgt_valid = 1'b0; tgt_duty = '0;
    #12 rst = 1'b0;
    @(negedge clk);
    check("lit_rst_duty",  int'(duty_cycle), 0);
    check("lit_rst_ready", int'(tgt_ready),  1);
    check("lit_rst_busy",  int'(busy),       0);
    check("lit_rst_at",    int'(at_target),  0);

    // Soft start 0 -> 16, accepted with pcnt = 10.
    goto(10);   tgt_valid = 1'b1; tgt_duty = 8'd16;
    goto(11);   tgt_valid = 1'b0; check("lit_up_busy", int'(busy), 1);
    goto(254);  check("lit_tick_254", int'(dut.period_tick), 0);
    goto(255);  check("lit_tick_255", int'(dut.period_tick), 1);
    goto(511);  check("lit_up_0", int'(duty_cycle), 0);
    goto(512);  check("lit_up_4", int'(duty_cycle), 4);
    goto(1024); check("lit_up_8", int'(duty_cycle), 8);
    goto(1536); check("lit_up_12", int'(duty_cycle), 12);
    goto(2047); check("lit_up_at0", int'(at_target), 0);
    goto(2048); check("lit_up_16", int'(duty_cycle), 16);
                check("lit_up_at1", int'(at_target), 1);
                check("lit_up_busy0", int'(busy), 0);

    // Ramp down 16 -> 6 with clamped last step, then same-value accept.
    goto(2050); tgt_valid = 1'b1; tgt_duty = 8'd6;
    goto(2051); tgt_valid = 1'b0;
    goto(2304); check("lit_dn_16", int'(duty_cycle), 16);
    goto(2560); check("lit_dn_12", int'(duty_cycle), 12);
    goto(3072); check("lit_dn_8", int'(duty_cycle), 8);
    goto(3584); check("lit_dn_6", int'(duty_cycle), 6);
                check("lit_dn_at", int'(at_target), 1);
    goto(3590); tgt_valid = 1'b1; tgt_duty = 8'd6;
    goto(3591); tgt_valid = 1'b0;
                check("lit_same_at", int'(at_target), 1);
                check("lit_same_duty", int'(duty_cycle), 6);

    // Kill from HOLD, with a target offered during shutdown.
    goto(3595); kill = 1'b1; tgt_valid = 1'b1; tgt_duty = 8'd50;
    goto(3596); check("lit_killh_duty", int'(duty_cycle), 0);
                check("lit_killh_ready", int'(tgt_ready), 0);
    goto(3598); kill = 1'b0; tgt_valid = 1'b0;
    goto(3599); check("lit_idle_ready", int'(tgt_ready), 1);
                check("lit_idle_at", int'(at_target), 0);

    // Ramp toward 200, kill at duty 12.
    goto(3600); tgt_valid = 1'b1; tgt_duty = 8'd200;
    goto(3601); tgt_valid = 1'b0;
    goto(5120); check("lit_k_12", int'(duty_cycle), 12);
    goto(5121); kill = 1'b1; tgt_valid = 1'b1; tgt_duty = 8'd50;
    goto(5122); check("lit_k_duty0", int'(duty_cycle), 0);
                check("lit_k_ready0", int'(tgt_ready), 0);
                check("lit_k_busy0", int'(busy), 0);
    goto(5125); kill = 1'b0; tgt_valid = 1'b0;
    goto(5126); check("lit_k_idle_duty", int'(duty_cycle), 0);
                check("lit_k_idle_busy", int'(busy), 0);

    // Ramp toward 200, retarget to 24 once duty reaches 20.
    goto(5130); tgt_valid = 1'b1; tgt_duty = 8'd200;
    goto(5131); tgt_valid = 1'b0;
    goto(7680); check("lit_rt_20", int'(duty_cycle), 20);
    goto(7700); tgt_valid = 1'b1; tgt_duty = 8'd24;
    goto(7701); tgt_valid = 1'b0;
    goto(7936); check("lit_rt_wait", int'(duty_cycle), 20);
    goto(8192); check("lit_rt_24", int'(duty_cycle), 24);
                check("lit_rt_at", int'(at_target), 1);

    // Retarget accepted on a period tick: that tick must not count.
    goto(8200); tgt_valid = 1'b1; tgt_duty = 8'd200;
    goto(8201); tgt_valid = 1'b0;
    goto(8704); check("lit_co_28", int'(duty_cycle), 28);
    goto(8959); check("lit_co_tick", int'(dut.period_tick), 1);
                tgt_valid = 1'b1; tgt_duty = 8'd100;
    goto(8960); tgt_valid = 1'b0;
    goto(9216); check("lit_co_nostep", int'(duty_cycle), 28);
    goto(9472); check("lit_co_32", int'(duty_cycle), 32);

    // Asynchronous reset mid-ramp, between clock edges.
    goto(9480);
    #2 rst = 1'b1;
    #1;
    check("lit_arst_duty",  int'(duty_cycle), 0);
    check("lit_arst_busy",  int'(busy),       0);
    check("lit_arst_at",    int'(at_target),  0);
    check("lit_arst_ready", int'(tgt_ready),  1);
    #20 rst = 1'b0;
    goto(300);
    check("lit_post_duty", int'(duty_cycle), 0);
    check("lit_post_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
